// File: rtl/ovl_pkg.sv
// Shared OVL checker definitions: severity and property-type codes, fire-vector
// layout and the common simulation report task.
`timescale 1ns/1ps
package ovl_pkg;

  localparam int OVL_FATAL   = 0;
  localparam int OVL_ERROR   = 1;
  localparam int OVL_WARNING = 2;
  localparam int OVL_INFO    = 3;

  localparam int OVL_ASSERT = 0;
  localparam int OVL_ASSUME = 1;
  localparam int OVL_IGNORE = 2;

  localparam int OVL_FIRE_WIDTH = 3;
  localparam int OVL_FIRE_RANGE = 0;
  localparam int OVL_FIRE_XZ    = 1;
  localparam int OVL_FIRE_COVER = 2;

`ifndef SYNTHESIS
  function automatic string ovl_prefix(input int severity);
    case (severity)
      OVL_FATAL:   return "OVL_FATAL";
      OVL_ERROR:   return "OVL_ERROR";
      OVL_WARNING: return "OVL_WARNING";
      default:     return "OVL_INFO";
    endcase
  endfunction

  // A fatal-severity report ends the simulation right after printing.
  task automatic ovl_report(input int severity, input string checker_name,
                            input string msg, input string text);
    $display("%s : %s : %s : %s : time %0t",
             ovl_prefix(severity), checker_name, msg, text, $time);
    if (severity == OVL_FATAL) $finish;
  endtask
`endif

endpackage

// File: rtl/ovl_delta_core.sv
// Combinational unsigned change magnitude and inclusive [min, max] range compare.
`timescale 1ns/1ps
module ovl_delta_core #(
  parameter int width = 1,
  parameter int min   = 0,
  parameter int max   = 1
) (
  input  logic [width-1:0] i_cur,
  input  logic [width-1:0] i_prev,
  output logic             o_out_of_range
);

  localparam logic [width:0] MIN_L = (width+1)'(min);
  localparam logic [width:0] MAX_L = (width+1)'(max);

  logic [width:0] w_cur_ext;
  logic [width:0] w_prev_ext;
  logic [width:0] w_delta;

  assign w_cur_ext  = {1'b0, i_cur};
  assign w_prev_ext = {1'b0, i_prev};

  // Subtract the smaller from the larger so 0 -> 2^width-1 never wraps.
  assign w_delta = (w_cur_ext >= w_prev_ext) ? (w_cur_ext - w_prev_ext)
                                             : (w_prev_ext - w_cur_ext);

  assign o_out_of_range = (w_delta < MIN_L) || (w_delta > MAX_L);

endmodule

// File: rtl/ovl_delta_checker.sv
// Passive checker: flags changes of test_expr whose magnitude falls outside
// [min, max], X/Z on test_expr, and (optionally) legal changes as cover pulses.
`timescale 1ns/1ps
module ovl_delta_checker
  import ovl_pkg::*;
#(
  parameter int severity_level = OVL_ERROR,
  parameter int width          = 1,
  parameter int min            = 0,
  parameter int max            = 1,
  parameter int property_type  = OVL_ASSERT,
  parameter     msg            = "VIOLATION",
  parameter int coverage_level = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [width-1:0]          test_expr,
  output logic [OVL_FIRE_WIDTH-1:0] fire
);

  logic [width-1:0]          r_prev;
  logic                      r_valid;
  logic [OVL_FIRE_WIDTH-1:0] r_fire;

  logic                      w_xz;
  logic                      w_prev_xz;
  logic                      w_check;
  logic                      w_change;
  logic                      w_out_of_range;
  logic                      w_viol;
  logic                      w_cover;
  logic                      w_xz_fire;
  logic [OVL_FIRE_WIDTH-1:0] w_fire_next;

  // Unknown values only exist in simulation; hardware sees constant zero.
`ifdef SYNTHESIS
  assign w_xz      = 1'b0;
  assign w_prev_xz = 1'b0;
`else
  assign w_xz      = $isunknown(test_expr);
  assign w_prev_xz = $isunknown(r_prev);
`endif

  assign w_check  = r_valid && enable && !w_xz && !w_prev_xz;
  assign w_change = w_check && (test_expr != r_prev);

  ovl_delta_core #(
    .width (width),
    .min   (min),
    .max   (max)
  ) u_core (
    .i_cur          (test_expr),
    .i_prev         (r_prev),
    .o_out_of_range (w_out_of_range)
  );

  assign w_viol    = w_change && w_out_of_range;
  assign w_cover   = (coverage_level != 0) && w_change && !w_out_of_range;
  assign w_xz_fire = r_valid && enable && w_xz;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_fire_next = '0;
    if (property_type != OVL_IGNORE) begin
      w_fire_next[OVL_FIRE_RANGE] = w_viol;
      w_fire_next[OVL_FIRE_XZ]    = w_xz_fire;
      w_fire_next[OVL_FIRE_COVER] = w_cover;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev  <= '0;
      r_valid <= 1'b0;
      r_fire  <= '0;
    end else begin
      r_prev  <= test_expr;
      r_valid <= 1'b1;
      r_fire  <= w_fire_next;
    end
  end

  assign fire = r_fire;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset && (property_type != OVL_IGNORE)) begin
      if (w_viol)
        ovl_report(severity_level, "OVL_DELTA", msg,
                   "Test expression changed by a delta outside the range specified by min and max");
      if (w_xz_fire)
        ovl_report(severity_level, "OVL_DELTA", msg, "test_expr contains illegal X/Z value");
    end
  end
`endif

endmodule

// File: tb/tb_ovl_delta_checker.sv
// Scoreboard bench for ovl_delta_checker (width 4, min 2, max 5, 10 ns clock),
// run on a plain instance and one with coverage enabled.
`timescale 1ns/1ps
module tb_ovl_delta_checker;

  localparam int W = 4;

  typedef struct {
    string      tag;
    logic [2:0] exp_plain;
    logic [2:0] exp_cov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] te;
  logic [2:0]   fire_plain;
  logic [2:0]   fire_cov;

  int checks = 0;
  int errors = 0;

  exp_t         sb[$];
  logic [W-1:0] m_prev;
  logic         m_valid;

  always #5 clk = ~clk;

  ovl_delta_checker #(
    .severity_level (1), .width (W), .min (2), .max (5),
    .property_type (0), .msg ("VIOLATION"), .coverage_level (0)
  ) dut (
    .clock (clk), .reset (rst_n), .enable (en), .test_expr (te), .fire (fire_plain)
  );

  ovl_delta_checker #(
    .severity_level (1), .width (W), .min (2), .max (5),
    .property_type (0), .msg ("VIOLATION"), .coverage_level (1)
  ) dut_cov (
    .clock (clk), .reset (rst_n), .enable (en), .test_expr (te), .fire (fire_cov)
  );

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the fire vector produced by the next edge.
  function automatic logic [2:0] model(input logic [W-1:0] v, input logic e, input bit cov);
    int d;
    if (!m_valid || !e) return 3'b000;
    if ($isunknown(v)) return 3'b010;
    if ($isunknown(m_prev) || v == m_prev) return 3'b000;
    d = (int'(v) > int'(m_prev)) ? int'(v) - int'(m_prev) : int'(m_prev) - int'(v);
    if (d < 2 || d > 5) return 3'b001;
    return cov ? 3'b100 : 3'b000;
  endfunction

  task automatic step(input string tag, input logic [W-1:0] v, input logic e);
    exp_t x;
    exp_t y;
    te = v;
    en = e;
    x.tag       = tag;
    x.exp_plain = model(v, e, 1'b0);
    x.exp_cov   = model(v, e, 1'b1);
    sb.push_back(x);
    m_prev  = v;
    m_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    y = sb.pop_front();
    check({y.tag, "/plain"}, fire_plain, y.exp_plain);
    check({y.tag, "/cov"},   fire_cov,   y.exp_cov);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] xv;
    xv    = 'x;
    rst_n = 1'b0;
    en    = 1'b1;
    te    = '0;
    m_prev  = '0;
    m_valid = 1'b0;
    #1;
    check("reset_plain", fire_plain, 3'b000);
    check("reset_cov",   fire_cov,   3'b000);

    // Activity while held in reset must stay silent.
    for (int i = 0; i < 3; i++) begin
      te = (i == 0) ? 4'd1 : (i == 1) ? 4'd2 : 4'd0;
      @(posedge clk);
      @(negedge clk);
      check("in_reset", fire_plain | fire_cov, 3'b000);
    end

    te    = 4'd2;
    rst_n = 1'b1;
    step("first_load", 4'd2, 1'b1);
    step("legal_2_4",  4'd4, 1'b1);
    step("legal_4_6",  4'd6, 1'b1);
    step("small_6_7",  4'd7, 1'b1);
    step("hold_7",     4'd7, 1'b1);
    step("large_7_0",  4'd0, 1'b1);
    step("large_0_6",  4'd6, 1'b1);
    step("large_6_0",  4'd0, 1'b1);
    step("min_0_2",    4'd2, 1'b1);
    step("min_2_0",    4'd0, 1'b1);
    step("max_0_5",    4'd5, 1'b1);
    step("hold_5",     4'd5, 1'b1);
    step("max_5_0",    4'd0, 1'b1);
    step("dis_0_15",   4'd15, 1'b0);
    step("reen_15_12", 4'd12, 1'b1);
    step("viol_12_6",  4'd6, 1'b1);
    step("en_fall",    4'd0, 1'b0);
    step("en_rise",    4'd0, 1'b1);
    step("xz",         xv,   1'b1);
    step("after_xz",   4'd4, 1'b1);
    step("legal_4_6b", 4'd6, 1'b1);
    step("settle_0",   4'd0, 1'b1);

    // Violation registered, then reset drops before the next edge.
    te = 4'd6;
    @(posedge clk);
    #1;
    check("pending_viol", fire_plain, 3'b001);
    rst_n = 1'b0;
    #1;
    check("async_clear_plain", fire_plain, 3'b000);
    check("async_clear_cov",   fire_cov,   3'b000);
    @(negedge clk);
    check("held_reset", fire_plain | fire_cov, 3'b000);
    m_prev  = '0;
    m_valid = 1'b0;
    rst_n   = 1'b1;
    step("post_reset_load", 4'd5, 1'b1);
    step("post_reset_legal", 4'd7, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ovl_delta_checker.md
# ovl_delta_checker

Synchronous assertion checker: every time a monitored bus changes value between consecutive sampled clock edges, it checks that the magnitude of the change lies within [min, max]. It flags violations on a registered fire vector and prints a simulation report. It sits alongside the RTL it observes in unit benches, clocked by the bench clock generator, and is otherwise passive.

## Interface
Parameters:
- severity_level, 1: 0 fatal, 1 error, 2 warning, 3 info.
- width, 1: test_expr width, at least 1.
- min, 0: smallest legal nonzero change magnitude.
- max, 1: largest legal change magnitude; requires min ≤ max < 2^width.
- property_type, 0: 0 assert, 1 assume, 2 ignore (no fire, no report).
- msg, "VIOLATION": text included in the report.
- coverage_level, 0: nonzero enables cover pulses on fire[2].

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  sampling clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- enable  in  1  check enable; when low, no checks are performed.
- test_expr  in  width  monitored value.
- fire  out  3  [0] range violation, [1] X/Z on test_expr, [2] cover (legal change).

## Operation
- Internal state:
  - prev: width bits.
  - valid: 1 bit; set when prev holds a post-reset sample.
- At each rising clock edge:
  - prev ← test_expr, regardless of enable.
  - valid ← 1.
- A change is detected when valid = 1, enable = 1 and test_expr ≠ prev.
- Delta is |test_expr − prev|, computed unsigned in width+1 bits. Both operands are unsigned; there is no wrap-around, so 0→15 with width = 4 gives delta 15.
- On a detected change:
  - Violation if delta < min or delta > max.
  - Both bounds are inclusive-legal.
- No change (delta 0) never fires, even when min > 0.
- Violation response:
  - fire[0] = 1.
  - Print "OVL_ERROR : OVL_DELTA : <msg> : Test expression changed by a delta outside the range specified by min and max", with $time. The prefix follows severity_level.
  - severity_level 0 calls $finish after the print.
- X/Z detection:
  - enable = 1 and test_expr contains X/Z: fire[1] = 1 and an "illegal X/Z" report.
  - No delta check is performed that cycle.
  - Simulation only; synthesizes to 0.
- Cover: coverage_level ≠ 0 and a legal change: fire[2] = 1.
- property_type 2 forces fire to 0 and suppresses reports.

## Timing
- Reset:
  - Asynchronous; while reset = 0: fire = 3'b000, valid = 0, prev = 0.
  - The first rising edge after reset release only loads prev; it never checks.
  - Reset asserted mid-operation clears fire immediately and cancels any pending check.
- Latency: a violation between the samples at edges N−1 and N appears on fire after edge N and holds for exactly one cycle. fire is registered.
- Consecutive violations give fire[0] high on consecutive cycles; there is no merging.
- enable falling clears fire at the next edge.
- enable rising compares against prev, which kept updating while enable was low.

## Structure
- Shared package ovl_pkg holds:
  - Severity constants: OVL_FATAL, OVL_ERROR, OVL_WARNING, OVL_INFO.
  - Property types: OVL_ASSERT, OVL_ASSUME, OVL_IGNORE.
  - OVL_FIRE_WIDTH = 3.
  - Fire bit indices.
  - The common report task: message prefix composed from severity.
- One natural sub-module, ovl_delta_core: combinational delta and range compare. The top level holds the registers, X check and reporting.
- Bench clock: ivl_uvm_ovl_clk_gen (existing bench module).
  - Parameter FREQ_IN_MHZ; single output port.
  - Free-running, 50% duty, period 1000/FREQ_IN_MHZ ns, starts low at time 0.
  - Benches use FREQ_IN_MHZ = 100, giving a 10 ns period.

## Test plan
All scenarios use width = 4, min = 2, max = 5, 100 MHz clock.
- Reset activity: reset low, test_expr 1→2→0 over 3 cycles → fire stays 000 and no report.
- Legal sequence: release reset with test_expr = 2, then 4, then 6 on successive cycles → fire[0] never asserts.
- Violation, delta too small: 6→7 (delta 1) → fire[0] = 1 for one cycle after the edge, ERROR report printed.
- Violation, delta too large and bounds: 0→6 (6) fires; 0→2 (2) and 0→5 (5) pass; a held value (delta 0) passes.
- Enable low and X/Z:
  - enable = 0 during 0→15 → no fire.
  - test_expr = 4'bx with enable = 1 → fire[1] pulses.
- Mid-run reset and coverage: a violation pending when reset drops → fire cleared asynchronously. With coverage_level = 1, 2→4 pulses fire[2].
